// File: rtl/fft_symbol_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : fft_symbol_scheduler
// Description : Ping-pong sample buffer writer and FFT start scheduler.
//               Optional macro FFT_SCHED_OVF_CNT_EN enables the Ovf_Count counter.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_symbol_scheduler #(
    parameter int SYM_LEN   = 64,
    parameter int CNT_WIDTH = 8
) (
    input  logic                      CLK,
    input  logic                      RST_n,
    input  logic                      In_Strobe,
    input  logic                      Providing_Long,
    input  logic                      Providing_Stream,
    input  logic                      Frame_Abort,
    input  logic                      FFT_Ready,
    input  logic                      FFT_Done,
    output logic                      Buf_Wr_En,
    output logic [$clog2(SYM_LEN):0]  Buf_Wr_Addr,
    output logic                      FFT_Start,
    output logic                      FFT_Bank,
    output logic                      FFT_Is_Long,
    output logic [CNT_WIDTH-1:0]      Symbol_Count,
    output logic                      Overflow,
    output logic                      Short_Symbol,
    output logic [CNT_WIDTH-1:0]      Ovf_Count
);
    localparam int               IDX_W    = $clog2(SYM_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SYM_LEN - 1);

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_FILL = 2'd1, W_DROP = 2'd2} wstate_t;
    typedef enum logic       {R_IDLE = 1'b0, R_BUSY = 1'b1} rstate_t;

    wstate_t              wstate_q, wstate_d;
    rstate_t              rstate_q, rstate_d;
    logic                 wr_bank_q, wr_bank_d;
    logic                 rd_bank_q, rd_bank_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [1:0]           full_q, full_d;
    logic [1:0]           tag_q, tag_d;
    logic                 cur_tag_q, cur_tag_d;
    logic                 start_q, start_d;
    logic                 short_q, short_d;
    logic                 ovf_q, ovf_d;
    logic [CNT_WIDTH-1:0] sym_cnt_q, sym_cnt_d;

    logic accept;
    logic flags_low;
    logic free_evt;
    logic wr_bank_free;
    logic wr_en;

    assign accept       = In_Strobe & (Providing_Long | Providing_Stream);
    assign flags_low    = ~Providing_Long & ~Providing_Stream;
    assign free_evt     = (rstate_q == R_BUSY) & FFT_Done;
    // A bank released on this very edge is already usable by the writer.
    assign wr_bank_free = ~full_q[wr_bank_q] | (free_evt & (rd_bank_q == wr_bank_q));

    always_comb begin
        wstate_d  = wstate_q;
        rstate_d  = rstate_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        idx_d     = idx_q;
        full_d    = full_q;
        tag_d     = tag_q;
        cur_tag_d = cur_tag_q;
        start_d   = 1'b0;
        short_d   = 1'b0;
        ovf_d     = ovf_q;
        sym_cnt_d = sym_cnt_q;
        wr_en     = 1'b0;

        if (free_evt) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
            rstate_d          = R_IDLE;
        end

        case (wstate_q)
            W_IDLE: begin
                if (accept) begin
                    idx_d = IDX_W'(1);
                    if (wr_bank_free) begin
                        wr_en     = 1'b1;
                        cur_tag_d = Providing_Long;
                        wstate_d  = W_FILL;
                    end else begin
                        ovf_d    = 1'b1;
                        wstate_d = W_DROP;
                    end
                end
            end
            W_FILL: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        full_d[wr_bank_q] = 1'b1;
                        tag_d[wr_bank_q]  = cur_tag_q;
                        wr_bank_d         = ~wr_bank_q;
                        idx_d             = '0;
                        wstate_d          = W_IDLE;
                        if (sym_cnt_q != '1)
                            sym_cnt_d = sym_cnt_q + 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else if (flags_low) begin
                    short_d  = 1'b1;
                    idx_d    = '0;
                    wstate_d = W_IDLE;
                end
            end
            W_DROP: begin
                if (accept) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d    = '0;
                        wstate_d = W_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else if (flags_low) begin
                    idx_d    = '0;
                    wstate_d = W_IDLE;
                end
            end
            default: begin
                idx_d    = '0;
                wstate_d = W_IDLE;
            end
        endcase

        // Using full_d lets the start pulse land in the cycle right after completion.
        if ((rstate_q == R_IDLE) && full_d[rd_bank_q] && FFT_Ready) begin
            start_d  = 1'b1;
            rstate_d = R_BUSY;
        end

        if (Frame_Abort) begin
            wstate_d  = W_IDLE;
            rstate_d  = R_IDLE;
            wr_bank_d = 1'b0;
            rd_bank_d = 1'b0;
            idx_d     = '0;
            full_d    = '0;
            tag_d     = '0;
            cur_tag_d = 1'b0;
            start_d   = 1'b0;
            short_d   = 1'b0;
            ovf_d     = 1'b0;
            sym_cnt_d = '0;
            wr_en     = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            wstate_q  <= W_IDLE;
            rstate_q  <= R_IDLE;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            idx_q     <= '0;
            full_q    <= '0;
            tag_q     <= '0;
            cur_tag_q <= 1'b0;
            start_q   <= 1'b0;
            short_q   <= 1'b0;
            ovf_q     <= 1'b0;
            sym_cnt_q <= '0;
        end else begin
            wstate_q  <= wstate_d;
            rstate_q  <= rstate_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            idx_q     <= idx_d;
            full_q    <= full_d;
            tag_q     <= tag_d;
            cur_tag_q <= cur_tag_d;
            start_q   <= start_d;
            short_q   <= short_d;
            ovf_q     <= ovf_d;
            sym_cnt_q <= sym_cnt_d;
        end
    end

`ifdef FFT_SCHED_OVF_CNT_EN
    logic [CNT_WIDTH-1:0] ovf_cnt_q, ovf_cnt_d;
    logic                 ovf_inc;

    assign ovf_inc = (wstate_q == W_IDLE) & accept & ~wr_bank_free;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (Frame_Abort)
            ovf_cnt_d = '0;
        else if (ovf_inc && (ovf_cnt_q != '1))
            ovf_cnt_d = ovf_cnt_q + 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n)
            ovf_cnt_q <= '0;
        else
            ovf_cnt_q <= ovf_cnt_d;
    end

    assign Ovf_Count = ovf_cnt_q;
`else
    assign Ovf_Count = '0;
`endif

    // Write enable is gated by reset so the port reads 0 throughout reset.
    assign Buf_Wr_En    = wr_en & RST_n;
    assign Buf_Wr_Addr  = {wr_bank_q, idx_q};
    assign FFT_Start    = start_q;
    assign FFT_Bank     = rd_bank_q;
    assign FFT_Is_Long  = tag_q[rd_bank_q];
    assign Symbol_Count = sym_cnt_q;
    assign Overflow     = ovf_q;
    assign Short_Symbol = short_q;

endmodule
`default_nettype wire

// File: doc/fft_symbol_scheduler.md
FFT_SYMBOL_SCHEDULER -- requirements
Module: fft_symbol_scheduler

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter: SYM_LEN, 64, samples per FFT symbol (power of two).
REQ-003 Parameter: CNT_WIDTH, 8, width of symbol and overflow counters.
REQ-004 CLK  in  1  rising-edge clock.
REQ-005 RST_n  in  1  asynchronous active-low reset.
REQ-006 In_Strobe  in  1  valid sample from the long-sync stage this cycle.
REQ-007 Providing_Long  in  1  current sample belongs to a long training symbol.
REQ-008 Providing_Stream  in  1  current sample belongs to a data symbol.
REQ-009 Frame_Abort  in  1  synchronous clear of all frame state.
REQ-010 FFT_Ready  in  1  FFT engine can accept a start.
REQ-011 FFT_Done  in  1  one-cycle pulse; FFT has finished reading its bank.
REQ-012 Buf_Wr_En  out  1  write enable to the ping-pong sample buffer.
REQ-013 Buf_Wr_Addr  out  log2(SYM_LEN)+1  {bank, index} write address.
REQ-014 FFT_Start  out  1  one-cycle start pulse to the FFT.
REQ-015 FFT_Bank  out  1  bank the FFT must read; valid while FFT_Start is high, held until FFT_Done.
REQ-016 FFT_Is_Long  out  1  tag of the started bank: 1 = long training symbol.
REQ-017 Symbol_Count  out  CNT_WIDTH  completed symbols this frame, saturating.
REQ-018 Overflow  out  1  sticky: a symbol was dropped because no bank was free.
REQ-019 Short_Symbol  out  1  one-cycle pulse; a partial symbol was discarded.
REQ-020 Ovf_Count  out  CNT_WIDTH  dropped-symbol count (see Configuration).

Function
REQ-021 Sample accepted SHALL be In_Strobe & (Providing_Long | Providing_Stream); write index increments per accepted sample.
REQ-022 Write FSM SHALL have states W_IDLE, W_FILL, W_DROP.
REQ-023 W_IDLE: on an accepted sample, target bank free -> W_FILL and write index 0; target bank full -> W_DROP, Overflow set, Ovf_Count incremented.
REQ-024 W_FILL: Buf_Wr_En = accepted sample, combinationally, with Buf_Wr_Addr = {bank, index}; the SYM_LEN-th sample marks the bank full, latches its tag (Providing_Long of the first sample), toggles the target bank, increments Symbol_Count and returns to W_IDLE.
REQ-025 W_FILL: if both Providing flags are low and 0 < index < SYM_LEN, SHALL discard the partial symbol, pulse Short_Symbol, leave the bank free and return to W_IDLE.
REQ-026 W_DROP: Buf_Wr_En = 0; SHALL count SYM_LEN accepted samples (or exit on both flags low), then return to W_IDLE.
REQ-027 Read FSM SHALL have states R_IDLE, R_BUSY; bank served is the oldest full bank (strict alternation, starting at bank 0).
REQ-028 R_IDLE -> R_BUSY when read bank full and FFT_Ready; FFT_Start pulses that cycle, registered, earliest in the cycle after the completing write.
REQ-029 R_BUSY -> R_IDLE on FFT_Done; bank freed and read bank toggled on the same edge.
REQ-030 A bank completing and a bank freed on the same edge SHALL both take effect; a bank freed on the edge where W_IDLE tests it counts as free.
REQ-031 Symbol_Count and Ovf_Count SHALL saturate at all-ones; they do not wrap.
REQ-032 Frame_Abort SHALL have priority over all other inputs, return both FSMs to idle, free both banks, zero the counters, the bank pointers and Overflow, and drop any in-flight FFT_Start.

Reset
REQ-033 While RST_n = 0, all registers and outputs SHALL be 0, states W_IDLE/R_IDLE and both banks free, asynchronously, including mid-symbol.
REQ-034 After RST_n deasserts, the first accepted sample SHALL be writable in the first clock edge.

Configuration
REQ-035 Macro FFT_SCHED_OVF_CNT_EN: defined -> Ovf_Count SHALL be a saturating counter of symbols entering W_DROP; undefined -> Ovf_Count SHALL be constant 0 and its register SHALL not exist; Overflow is present either way.

Verification
REQ-036 64 long samples, FFT_Ready=1 -> 64 writes at addr 0..63, FFT_Start one cycle later with FFT_Bank=0, FFT_Is_Long=1, Symbol_Count=1.
REQ-037 FFT_Ready=0, three 64-sample stream symbols -> banks 0 and 1 filled, third symbol gives no writes, Overflow=1, Ovf_Count=1 (macro on) or 0 (macro off).
REQ-038 Flags drop after 20 samples -> Short_Symbol pulses once, next symbol writes from index 0 of the same bank, Symbol_Count unchanged.
REQ-039 FFT_Done for bank 0 on the same edge as the 64th sample of bank 1 -> bank 1 full, bank 0 free, next FFT_Start has FFT_Bank=1, next symbol written to bank 0.
REQ-040 RST_n low at sample 30, then Frame_Abort mid-symbol in a second run -> all outputs 0, no FFT_Start, next symbol written at addr 0.
REQ-041 300 completed symbols -> Symbol_Count holds 255.
